// File: rtl/spi_master.sv
// spi_master: single-byte SPI bus master with one chip select, CPOL/CPHA
// selectable at elaboration, and a valid/ready byte interface.
// Optional build macro: SPI_MASTER_LSB_FIRST_EN (shift and capture LSB first;
// MSB first when undefined).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | CS high, o_Tx_Ready high, waiting for i_Tx_Valid
// TRANSFER | CS low, generating the 16 SCLK edges of one byte
// CS_HOLD  | CS low for one half bit after the last edge, then completion
// CS_GAP   | CS high for CS_IDLE_CLKS clocks before accepting the next byte
module spi_master #(
  parameter int CPOL              = 0,
  parameter int CPHA              = 0,
  parameter int CLKS_PER_HALF_BIT = 20,
  parameter int CS_IDLE_CLKS      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_Tx_Byte,
  input  logic       i_Tx_Valid,
  output logic       o_Tx_Ready,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Ready,
  input  logic       i_SPI_Miso,
  output logic       o_SPI_CSLow,
  output logic       o_SPI_Mosi,
  output logic       o_SPI_Clk
);

  localparam logic CPOL_L  = (CPOL != 0);
  localparam logic CPHA_L  = (CPHA != 0);
  localparam int   CNT_MAX = (CLKS_PER_HALF_BIT > CS_IDLE_CLKS) ? CLKS_PER_HALF_BIT : CS_IDLE_CLKS;
  localparam int   CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] GAP_RELOAD  = CW'(CS_IDLE_CLKS - 1);

  typedef enum logic [1:0] {IDLE, TRANSFER, CS_HOLD, CS_GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    edge_q, edge_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic          tx_rdy_q, tx_rdy_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;

  logic [7:0]    tx_ord;
  logic [4:0]    edge_num;
  logic          leading;
  logic          drive_edge;
  logic          sample_edge;

  // The shifter always works MSB first; LSB-first order is obtained by
  // mirroring the byte on the way in and on the way out.
  function automatic logic [7:0] bit_order(input logic [7:0] b);
    logic [7:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
    r = b;
`endif
    return r;
  endfunction

  // Edge classification: odd edges lead away from CPOL, even edges return.
  always_comb begin
    tx_ord      = bit_order(i_Tx_Byte);
    edge_num    = edge_q + 5'd1;
    leading     = edge_num[0];
    drive_edge  = CPHA_L ? leading : (!leading && (edge_num != 5'd16));
    sample_edge = CPHA_L ? !leading : leading;
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_byte_d = rx_byte_q;
    rx_rdy_d  = 1'b0;
    tx_rdy_d  = tx_rdy_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    case (state_q)
      IDLE: begin
        if (i_Tx_Valid && tx_rdy_q) begin
          state_d  = TRANSFER;
          tx_rdy_d = 1'b0;
          cs_d     = 1'b0;
          cnt_d    = HALF_RELOAD;
          edge_d   = 5'd0;
          rx_d     = 8'h00;
          if (CPHA_L) begin
            // First bit goes out on the leading edge.
            tx_d   = tx_ord;
            mosi_d = 1'b0;
          end else begin
            // First bit must already be on MOSI when CS falls.
            tx_d   = {tx_ord[6:0], 1'b0};
            mosi_d = tx_ord[7];
          end
        end
      end
      TRANSFER: begin
        if (cnt_q == '0) begin
          cnt_d  = HALF_RELOAD;
          sclk_d = ~sclk_q;
          edge_d = edge_num;
          if (drive_edge) begin
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (sample_edge) rx_d = {rx_q[6:0], i_SPI_Miso};
          if (edge_num == 5'd16) state_d = CS_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CS_HOLD: begin
        if (cnt_q == '0) begin
          state_d   = CS_GAP;
          cnt_d     = GAP_RELOAD;
          cs_d      = 1'b1;
          mosi_d    = 1'b0;
          rx_byte_d = bit_order(rx_q);
          rx_rdy_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CS_GAP: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          tx_rdy_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      edge_q    <= 5'd0;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      rx_byte_q <= 8'h00;
      rx_rdy_q  <= 1'b0;
      tx_rdy_q  <= 1'b1;
      sclk_q    <= CPOL_L;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_byte_q <= rx_byte_d;
      rx_rdy_q  <= rx_rdy_d;
      tx_rdy_q  <= tx_rdy_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
    end
  end

  assign o_Tx_Ready  = tx_rdy_q;
  assign o_Rx_Byte   = rx_byte_q;
  assign o_Rx_Ready  = rx_rdy_q;
  assign o_SPI_CSLow = cs_q;
  assign o_SPI_Mosi  = mosi_q;
  assign o_SPI_Clk   = sclk_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: one instance per SPI mode (index = CPOL*2 + CPHA),
// each with an event-driven slave model; expectations kept in a scoreboard.
`timescale 1ns/1ps
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [7:0] tx_byte  [4];
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic [7:0] rx_byte  [4];
  logic       rx_ready [4];
  logic       cs_n     [4];
  logic       mosi     [4];
  logic       sclk     [4];
  logic [7:0] slv_tx   [4];
  logic [7:0] slv_rx   [4];
  logic       slv_first[4];
  int         slv_bits [4];

  typedef struct {
    int         m;
    logic [7:0] rx;
    logic [7:0] slv;
  } exp_t;
  exp_t sb[$];

  int  checks = 0;
  int  errors = 0;
  time t_acc  = 0;

  always #5 clk = ~clk;

  function automatic logic out_bit(input logic [7:0] b);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return b[0];
`else
    return b[7];
`endif
  endfunction

  function automatic logic [7:0] shift_out(input logic [7:0] b);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return b >> 1;
`else
    return b << 1;
`endif
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] r, input logic d);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return {d, r[7:1]};
`else
    return {r[6:0], d};
`endif
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_mode
    localparam int   P   = g / 2;
    localparam int   A   = g % 2;
    localparam logic POL = (P != 0);
    logic [7:0] sh;
    logic [7:0] rxs;
    logic       first;
    int         nb;
    logic       miso_l;

    spi_master #(.CPOL(P), .CPHA(A)) u_dut (
      .clk        (clk),
      .reset      (rst_b),
      .i_Tx_Byte  (tx_byte[g]),
      .i_Tx_Valid (tx_valid[g]),
      .o_Tx_Ready (tx_ready[g]),
      .o_Rx_Byte  (rx_byte[g]),
      .o_Rx_Ready (rx_ready[g]),
      .i_SPI_Miso (miso_l),
      .o_SPI_CSLow(cs_n[g]),
      .o_SPI_Mosi (mosi[g]),
      .o_SPI_Clk  (sclk[g])
    );

    initial begin
      sh = 8'h00; rxs = 8'h00; first = 1'b0; nb = 0; miso_l = 1'b0;
    end

    always @(negedge cs_n[g]) begin
      sh = slv_tx[g]; rxs = 8'h00; nb = 0;
      if (A == 0) begin
        miso_l = out_bit(sh);
        sh     = shift_out(sh);
      end
    end

    always @(sclk[g]) begin
      if (cs_n[g] === 1'b0) begin
        if ((sclk[g] != POL) ^ (A != 0)) begin
          if (nb == 0) first = mosi[g];
          rxs = shift_in(rxs, mosi[g]);
          nb++;
        end else begin
          miso_l = out_bit(sh);
          sh     = shift_out(sh);
        end
      end
    end

    assign slv_rx[g]    = rxs;
    assign slv_first[g] = first;
    assign slv_bits[g]  = nb;
  end

  function automatic int rel();
    return int'(($time - t_acc + 5) / 10);
  endfunction

  task automatic wait_ready(input int m);
    int n = 0;
    while (tx_ready[m] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_ready[m] !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready m%0d: tx_ready=%b expected 1 within 1000 cycles", m, tx_ready[m]);
    end
  endtask

  task automatic start_xfer(input int m, input logic [7:0] tx, input logic [7:0] sret,
                            input bit hold, input bit expect_done);
    exp_t e;
    slv_tx[m]   = sret;
    tx_byte[m]  = tx;
    tx_valid[m] = 1'b1;
    if (expect_done) begin
      e.m = m; e.rx = sret; e.slv = tx;
      sb.push_back(e);
    end
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    if (!hold) tx_valid[m] = 1'b0;
  endtask

  task automatic finish_xfer(input int m, input int poke_cyc, output logic [7:0] rx_got,
                             output int n_pulse, output int c_rx, output int c_csr,
                             output int c_rdy, output int n_bad);
    logic pol = (m >= 2);
    int   cur;
    rx_got = 8'h00; n_pulse = 0; c_rx = -1; c_csr = -1; c_rdy = -1; n_bad = 0;
    for (int i = 0; i < 2000; i++) begin
      cur = rel();
      if (poke_cyc != 0 && cur == poke_cyc) begin
        tx_byte[m] = 8'hFF; tx_valid[m] = 1'b1;
      end
      if (poke_cyc != 0 && cur == poke_cyc + 1) tx_valid[m] = 1'b0;
      if (cs_n[m] === 1'b1 && sclk[m] !== pol) n_bad++;
      if (rx_ready[m] === 1'b1) begin
        n_pulse++; c_rx = cur; rx_got = rx_byte[m];
      end
      if (cs_n[m] === 1'b1 && c_csr < 0) c_csr = cur;
      if (tx_ready[m] === 1'b1) begin
        c_rdy = cur;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    for (int m = 0; m < 4; m++) begin
      tx_byte[m] = 8'h00; tx_valid[m] = 1'b0; slv_tx[m] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      logic pol = (m >= 2);
      checks += 6;
      if (cs_n[m] !== 1'b1) begin errors++; $display("FAIL reset_cs m%0d: got %b expected 1", m, cs_n[m]); end
      if (sclk[m] !== pol) begin errors++; $display("FAIL reset_sclk m%0d: got %b expected %b", m, sclk[m], pol); end
      if (mosi[m] !== 1'b0) begin errors++; $display("FAIL reset_mosi m%0d: got %b expected 0", m, mosi[m]); end
      if (rx_byte[m] !== 8'h00) begin errors++; $display("FAIL reset_rx_byte m%0d: got %h expected 00", m, rx_byte[m]); end
      if (rx_ready[m] !== 1'b0) begin errors++; $display("FAIL reset_rx_ready m%0d: got %b expected 0", m, rx_ready[m]); end
      if (tx_ready[m] !== 1'b1) begin errors++; $display("FAIL reset_tx_ready m%0d: got %b expected 1", m, tx_ready[m]); end
    end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [7:0] rx_got;
    int np, crx, ccs, crdy, nbad;
    exp_t e;
    wait_ready(0);
    start_xfer(0, 8'hA5, 8'h3C, 1'b0, 1'b1);
    checks += 2;
    if (cs_n[0] !== 1'b0) begin errors++; $display("FAIL m0_cs_cycle1: got %b expected 0", cs_n[0]); end
    if (tx_ready[0] !== 1'b0) begin errors++; $display("FAIL m0_ready_cycle1: got %b expected 0", tx_ready[0]); end
    finish_xfer(0, 0, rx_got, np, crx, ccs, crdy, nbad);
    e = sb.pop_front();
    checks += 9;
    if (rx_got !== e.rx) begin errors++; $display("FAIL m0_rx_byte: got %h expected %h", rx_got, e.rx); end
    if (slv_rx[0] !== e.slv) begin errors++; $display("FAIL m0_slave_rx: got %h expected %h", slv_rx[0], e.slv); end
    if (slv_bits[0] !== 8) begin errors++; $display("FAIL m0_slave_bits: got %0d expected 8", slv_bits[0]); end
    if (np !== 1) begin errors++; $display("FAIL m0_rx_pulses: got %0d expected 1", np); end
    if (crx !== 341) begin errors++; $display("FAIL m0_rx_cycle: got %0d expected 341", crx); end
    if (ccs !== 341) begin errors++; $display("FAIL m0_cs_rise_cycle: got %0d expected 341", ccs); end
    if (crdy !== 345) begin errors++; $display("FAIL m0_ready_cycle: got %0d expected 345", crdy); end
    if (nbad !== 0) begin errors++; $display("FAIL m0_idle_sclk: got %0d bad samples expected 0", nbad); end
    if (mosi[0] !== 1'b0) begin errors++; $display("FAIL m0_mosi_idle: got %b expected 0", mosi[0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx_got;
    int np, crx, ccs, crdy, nbad;
    exp_t e;
    exp_t e2;
    wait_ready(0);
    start_xfer(0, 8'hA5, 8'h3C, 1'b1, 1'b1);
    tx_byte[0] = 8'h5A;
    slv_tx[0]  = 8'h96;
    e2.m = 0; e2.rx = 8'h96; e2.slv = 8'h5A;
    sb.push_back(e2);
    finish_xfer(0, 0, rx_got, np, crx, ccs, crdy, nbad);
    e = sb.pop_front();
    checks += 4;
    if (slv_rx[0] !== e.slv) begin errors++; $display("FAIL b2b_first_slave_rx: got %h expected %h", slv_rx[0], e.slv); end
    if (rx_got !== e.rx) begin errors++; $display("FAIL b2b_first_rx_byte: got %h expected %h", rx_got, e.rx); end
    if (crdy !== 345) begin errors++; $display("FAIL b2b_ready_cycle: got %0d expected 345", crdy); end
    if (crdy - ccs !== 4) begin errors++; $display("FAIL b2b_cs_gap: got %0d expected 4", crdy - ccs); end
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    checks += 2;
    if (cs_n[0] !== 1'b0) begin errors++; $display("FAIL b2b_second_cs: got %b expected 0", cs_n[0]); end
    if (tx_ready[0] !== 1'b0) begin errors++; $display("FAIL b2b_second_ready: got %b expected 0", tx_ready[0]); end
    finish_xfer(0, 0, rx_got, np, crx, ccs, crdy, nbad);
    e = sb.pop_front();
    checks += 3;
    if (slv_rx[0] !== e.slv) begin errors++; $display("FAIL b2b_second_slave_rx: got %h expected %h", slv_rx[0], e.slv); end
    if (rx_got !== e.rx) begin errors++; $display("FAIL b2b_second_rx_byte: got %h expected %h", rx_got, e.rx); end
    if (crx !== 341) begin errors++; $display("FAIL b2b_second_rx_cycle: got %0d expected 341", crx); end
  endtask

  task automatic test_modes();
    logic [7:0] rx_got;
    int np, crx, ccs, crdy, nbad;
    exp_t e;
    for (int m = 1; m < 4; m++) begin
      wait_ready(m);
      start_xfer(m, 8'hA5, 8'h3C, 1'b0, 1'b1);
      finish_xfer(m, 0, rx_got, np, crx, ccs, crdy, nbad);
      e = sb.pop_front();
      checks += 5;
      if (rx_got !== e.rx) begin errors++; $display("FAIL mode%0d_rx_byte: got %h expected %h", m, rx_got, e.rx); end
      if (slv_rx[m] !== e.slv) begin errors++; $display("FAIL mode%0d_slave_rx: got %h expected %h", m, slv_rx[m], e.slv); end
      if (np !== 1) begin errors++; $display("FAIL mode%0d_rx_pulses: got %0d expected 1", m, np); end
      if (crx !== 341) begin errors++; $display("FAIL mode%0d_rx_cycle: got %0d expected 341", m, crx); end
      if (nbad !== 0) begin errors++; $display("FAIL mode%0d_idle_sclk: got %0d bad samples expected 0", m, nbad); end
    end
  endtask

  task automatic test_ignore_midxfer();
    logic [7:0] rx_got;
    int np, crx, ccs, crdy, nbad;
    int lows = 0;
    exp_t e;
    wait_ready(0);
    start_xfer(0, 8'hA5, 8'h3C, 1'b0, 1'b1);
    finish_xfer(0, 100, rx_got, np, crx, ccs, crdy, nbad);
    e = sb.pop_front();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cs_n[0] !== 1'b1) lows++;
    end
    checks += 4;
    if (slv_rx[0] !== e.slv) begin errors++; $display("FAIL mid_slave_rx: got %h expected %h", slv_rx[0], e.slv); end
    if (rx_got !== e.rx) begin errors++; $display("FAIL mid_rx_byte: got %h expected %h", rx_got, e.rx); end
    if (np !== 1) begin errors++; $display("FAIL mid_rx_pulses: got %0d expected 1", np); end
    if (lows !== 0) begin errors++; $display("FAIL mid_extra_xfer: got %0d cs-low cycles expected 0", lows); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    wait_ready(0);
    checks++;
    if (rx_byte[0] !== 8'h3C) begin errors++; $display("FAIL abort_pre_rx_byte: got %h expected 3c", rx_byte[0]); end
    start_xfer(0, 8'hA5, 8'h3C, 1'b0, 1'b0);
    while (rel() < 150) begin
      @(negedge clk);
      if (rx_ready[0] === 1'b1) pulses++;
    end
    rst_b = 1'b0;
    @(negedge clk);
    checks += 5;
    if (cs_n[0] !== 1'b1) begin errors++; $display("FAIL abort_cs: got %b expected 1", cs_n[0]); end
    if (sclk[0] !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b expected 0", sclk[0]); end
    if (rx_byte[0] !== 8'h00) begin errors++; $display("FAIL abort_rx_byte: got %h expected 00", rx_byte[0]); end
    if (tx_ready[0] !== 1'b1) begin errors++; $display("FAIL abort_tx_ready: got %b expected 1", tx_ready[0]); end
    if (rx_ready[0] !== 1'b0) begin errors++; $display("FAIL abort_rx_ready: got %b expected 0", rx_ready[0]); end
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rx_ready[0] === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort_no_pulse: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_bit_order();
    logic [7:0] rx_got;
    int np, crx, ccs, crdy, nbad;
    logic exp_first;
    exp_t e;
`ifdef SPI_MASTER_LSB_FIRST_EN
    exp_first = 1'b1;
`else
    exp_first = 1'b0;
`endif
    wait_ready(0);
    start_xfer(0, 8'h01, 8'h80, 1'b0, 1'b1);
    finish_xfer(0, 0, rx_got, np, crx, ccs, crdy, nbad);
    e = sb.pop_front();
    checks += 3;
    if (slv_first[0] !== exp_first) begin errors++; $display("FAIL order_first_mosi: got %b expected %b", slv_first[0], exp_first); end
    if (slv_rx[0] !== e.slv) begin errors++; $display("FAIL order_slave_rx: got %h expected %h", slv_rx[0], e.slv); end
    if (rx_got !== e.rx) begin errors++; $display("FAIL order_rx_byte: got %h expected %h", rx_got, e.rx); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mode0();
    test_back_to_back();
    test_modes();
    test_ignore_midxfer();
    test_reset_abort();
    test_bit_order();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-byte SPI bus master with one chip-select, configurable clock polarity and phase, and a valid/ready byte interface toward the fabric. It serialises one byte per transaction on MOSI and captures one full-duplex byte from MISO. It sits between a peripheral driver (for example the accelerometer register engine) and an external SPI slave device.

## Interface
- CPOL, 0, idle level of o_SPI_Clk (0 = idle low, 1 = idle high).
- CPHA, 0, 0 = sample on leading edge and shift on trailing; 1 = shift on leading edge and sample on trailing.
- CLKS_PER_HALF_BIT, 20, system clocks per SCLK half period; legal range ≥ 2.
- CS_IDLE_CLKS, 4, minimum clocks CS stays high between transactions; legal range ≥ 1.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- i_Tx_Byte  in  8  byte to transmit; sampled only on acceptance.
- i_Tx_Valid  in  1  request to start a transaction.
- o_Tx_Ready  out  1  high when a new byte can be accepted.
- o_Rx_Byte  out  8  last byte received; held until the next completion.
- o_Rx_Ready  out  1  one-cycle pulse when o_Rx_Byte updates.
- i_SPI_Miso  in  1  serial data from the slave.
- o_SPI_CSLow  out  1  chip select, active low.
- o_SPI_Mosi  out  1  serial data to the slave.
- o_SPI_Clk  out  1  SCLK.

## Operation
- All outputs are registered.
- Reset values: o_SPI_CSLow=1, o_SPI_Clk=CPOL, o_SPI_Mosi=0, o_Rx_Byte=0x00, o_Rx_Ready=0, o_Tx_Ready=1, FSM=IDLE.
- A byte is accepted when i_Tx_Valid and o_Tx_Ready are both high on a clock edge. On acceptance, i_Tx_Byte is latched and o_Tx_Ready drops on the next cycle. Changes to i_Tx_Byte after acceptance are ignored.
- Bit order is MSB first (see Configuration). Each transaction carries exactly 8 bits and has 16 SCLK edges.
- FSM states: IDLE → TRANSFER (on acceptance; CS low) → CS_HOLD (after edge 16) → CS_GAP (CS high) → IDLE.
- CPHA=0:
  - Bit 7 is on MOSI at the moment CS falls.
  - Odd (leading) edges sample MISO into the shift register.
  - Even (trailing) edges drive the next bit on MOSI.
- CPHA=1:
  - Odd (leading) edges drive bits 7..0.
  - Even (trailing) edges sample MISO.
- MOSI returns to 0 when CS rises.
- i_Tx_Valid asserted while o_Tx_Ready is low is ignored (not queued).
- If i_Tx_Valid is held high, a new transaction starts on the cycle o_Tx_Ready returns high.
- Reset asserted mid-transaction aborts it on that edge: all outputs take their reset values, no o_Rx_Ready pulse, o_Rx_Byte cleared.

## Timing
- Let H = CLKS_PER_HALF_BIT and let cycle 0 be the acceptance edge.
- Cycle 1: o_SPI_CSLow=0, o_Tx_Ready=0.
- SCLK edge k (k=1..16) occurs at cycle 1+k·H. Edges alternate away from and back to CPOL.
- Cycle 1+17·H: o_SPI_CSLow=1, o_Rx_Ready=1 for exactly one cycle, and o_Rx_Byte is valid.
- Cycle 1+17·H+CS_IDLE_CLKS: o_Tx_Ready=1.
- With defaults, CS falls at cycle 1 and rises at cycle 341; ready returns at cycle 345.
- o_SPI_Clk never glitches. It equals CPOL whenever CS is high.

## Configuration
- SPI_MASTER_LSB_FIRST_EN: when defined, both TX and RX use LSB-first order. Bit 0 is shifted first, and the first received bit lands in o_Rx_Byte[0].
- When undefined (default), both directions are MSB first as described above.

## Test plan
- Mode 0, loopback slave model returning 0x3C, send 0xA5 → MOSI shows 1,0,1,0,0,1,0,1 on leading edges; slave receives 0xA5; o_Rx_Byte=0x3C with one o_Rx_Ready pulse at cycle 341.
- Hold i_Tx_Valid high across completion with i_Tx_Byte=0x5A → second transaction starts at cycle 345; slave receives 0x5A; CS high for exactly 4 cycles between transactions.
- Repeat 0xA5/0x3C exchange for (CPOL,CPHA)=(0,1),(1,0),(1,1) → idle SCLK equals CPOL and received bytes are correct in every mode.
- Change i_Tx_Byte to 0xFF and pulse i_Tx_Valid mid-transfer → transmitted byte unchanged; no extra transaction.
- Assert reset at cycle 150 of a transfer → next cycle CS=1, SCLK=CPOL, o_Rx_Byte=0x00, o_Tx_Ready=1, no o_Rx_Ready pulse.
- Build with SPI_MASTER_LSB_FIRST_EN, send 0x01 to a slave returning 0x80 → MOSI first bit is 1; o_Rx_Byte=0x80 when the slave model is also LSB-first.
